// File: rtl/if_fetch_buffer_pkg.sv
// Shared definitions for the fetch-stage instruction buffer.
// Holds default sizing parameters, the buffered entry layout, the fetch
// exception codes shared with the ID stage, and a small popcount helper.
package if_fetch_buffer_pkg;

    localparam int unsigned FETCH_W_DEF = 2;
    localparam int unsigned ISSUE_W_DEF = 2;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned INST_W_DEF  = 32;

    // One buffered instruction at default widths.
    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
        logic                  excep;
    } fetch_entry_t;

    // Fetch-side exception codes decoded by ID when out_excep_o is set.
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;

    // Population count of up to four lanes (FETCH_W and ISSUE_W are <= 4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/if_fetch_buffer_ram.sv
// fetch_entry_ram: DEPTH-entry storage for {pc, inst, excep}.
// Ports:
//   clk                  write clock
//   wr_en[FETCH_W]       per-slot write enable, slot k written at wr_base+k
//   wr_base              write base index (queue tail)
//   wr_pc/wr_inst/wr_excep  slot data, slot 0 in LSBs
//   rd_base              read base index (queue head)
//   rd_pc/rd_inst/rd_excep  combinational read of entries rd_base+k
// Data is not reset; validity is tracked by the owner's count.
module fetch_entry_ram #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned FETCH_W = 2,
    parameter int unsigned ISSUE_W = 2,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned INST_W  = 32,
    parameter int unsigned AW      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic [FETCH_W-1:0]        wr_en,
    input  logic [AW-1:0]             wr_base,
    input  logic [FETCH_W*PC_W-1:0]   wr_pc,
    input  logic [FETCH_W*INST_W-1:0] wr_inst,
    input  logic [FETCH_W-1:0]        wr_excep,
    input  logic [AW-1:0]             rd_base,
    output logic [ISSUE_W*PC_W-1:0]   rd_pc,
    output logic [ISSUE_W*INST_W-1:0] rd_inst,
    output logic [ISSUE_W-1:0]        rd_excep
);

    logic [PC_W-1:0]   pc_mem    [DEPTH];
    logic [INST_W-1:0] inst_mem  [DEPTH];
    logic              excep_mem [DEPTH];

    logic [AW-1:0] wr_idx [FETCH_W];

    // Index arithmetic is AW bits wide, so it wraps modulo DEPTH.
    always_comb begin
        for (int unsigned k = 0; k < FETCH_W; k++) begin
            wr_idx[k] = wr_base + AW'(k);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < FETCH_W; k++) begin
            if (wr_en[k]) begin
                pc_mem[wr_idx[k]]    <= wr_pc[k*PC_W +: PC_W];
                inst_mem[wr_idx[k]]  <= wr_inst[k*INST_W +: INST_W];
                excep_mem[wr_idx[k]] <= wr_excep[k];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] rd_idx;
        rd_idx   = '0;
        rd_pc    = '0;
        rd_inst  = '0;
        rd_excep = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            rd_idx                       = rd_base + AW'(k);
            rd_pc[k*PC_W +: PC_W]        = pc_mem[rd_idx];
            rd_inst[k*INST_W +: INST_W]  = inst_mem[rd_idx];
            rd_excep[k]                  = excep_mem[rd_idx];
        end
    end

endmodule

// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer: circular instruction queue between ICache response and ID.
// Accepts up to FETCH_W instructions per cycle, presents up to ISSUE_W lines
// per cycle, truncates issue groups at exceptions / pending interrupts and
// clears all buffered state in one cycle on flush.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush_i               drop all buffered state at the next edge
//   int_pending_i         interrupt pending; tags line 0, issues it alone
//   in_valid_i/in_ready_o fetch group handshake (ready = room for FETCH_W)
//   in_mask_i/in_pc_i/in_inst_i/in_excep_i  fetch group slots
//   id_allowin_i          ID consumes all presented lines
//   out_valid_o/out_pc_o/out_inst_o/out_excep_o/out_int_o  lines to ID
//   count_o               occupied entries
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
#(
    parameter int unsigned FETCH_W = FETCH_W_DEF,
    parameter int unsigned ISSUE_W = ISSUE_W_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned PC_W    = PC_W_DEF,
    parameter int unsigned INST_W  = INST_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush_i,
    input  logic                         int_pending_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [FETCH_W-1:0]           in_mask_i,
    input  logic [FETCH_W*PC_W-1:0]      in_pc_i,
    input  logic [FETCH_W*INST_W-1:0]    in_inst_i,
    input  logic [FETCH_W-1:0]           in_excep_i,
    input  logic                         id_allowin_i,
    output logic [ISSUE_W-1:0]           out_valid_o,
    output logic [ISSUE_W*PC_W-1:0]      out_pc_o,
    output logic [ISSUE_W*INST_W-1:0]    out_inst_o,
    output logic [ISSUE_W-1:0]           out_excep_o,
    output logic                         out_int_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0]      head;
    logic [AW-1:0]      tail;
    logic [CW-1:0]      count;
    logic [CW-1:0]      free_slots;
    logic [CW-1:0]      push_n;
    logic [CW-1:0]      pop_n;
    logic               push;
    logic               pop;
    logic [FETCH_W-1:0] wr_en;
    logic [ISSUE_W-1:0] rd_excep;
    logic [ISSUE_W-1:0] line_valid;

    // Ready looks only at registered occupancy; a same-cycle pop does not help.
    assign free_slots = CW'(DEPTH) - count;
    assign in_ready_o = !flush_i && (free_slots >= CW'(FETCH_W));

    assign push   = in_valid_i && in_ready_o;
    assign wr_en  = push ? in_mask_i : '0;
    assign push_n = push ? CW'(popcount4(4'(in_mask_i))) : '0;

    fetch_entry_ram #(
        .DEPTH   (DEPTH),
        .FETCH_W (FETCH_W),
        .ISSUE_W (ISSUE_W),
        .PC_W    (PC_W),
        .INST_W  (INST_W),
        .AW      (AW)
    ) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_base  (tail),
        .wr_pc    (in_pc_i),
        .wr_inst  (in_inst_i),
        .wr_excep (in_excep_i),
        .rd_base  (head),
        .rd_pc    (out_pc_o),
        .rd_inst  (out_inst_o),
        .rd_excep (rd_excep)
    );

    // Group truncation: an excepting line ends the group (it may still issue
    // as line 0), and a pending interrupt restricts issue to line 0 only.
    always_comb begin
        logic blocked;
        blocked    = 1'b0;
        line_valid = '0;
        for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (!flush_i && !blocked && (count > CW'(k)) &&
                (k == 0 || (!rd_excep[k] && !int_pending_i))) begin
                line_valid[k] = 1'b1;
            end
            blocked = blocked | rd_excep[k];
        end
    end

    assign out_valid_o = line_valid;
    assign out_excep_o = rd_excep & line_valid;
    assign out_int_o   = int_pending_i && line_valid[0];
    assign count_o     = count;

    assign pop   = id_allowin_i && line_valid[0];
    assign pop_n = pop ? CW'(popcount4(4'(line_valid))) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(pop_n);
            tail  <= tail + AW'(push_n);
            count <= count + push_n - pop_n;
        end
    end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_buffer;
    import if_fetch_buffer_pkg::*;

    localparam int unsigned FW = 2;
    localparam int unsigned IW = 2;
    localparam int unsigned D  = 8;
    localparam int unsigned CW = $clog2(D) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             int_p;
    logic             in_valid;
    logic             in_ready;
    logic [FW-1:0]    in_mask;
    logic [FW*32-1:0] in_pc;
    logic [FW*32-1:0] in_inst;
    logic [FW-1:0]    in_excep;
    logic             allowin;
    logic [IW-1:0]    out_valid;
    logic [IW*32-1:0] out_pc;
    logic [IW*32-1:0] out_inst;
    logic [IW-1:0]    out_excep;
    logic             out_int;
    logic [CW-1:0]    count;

    always #5 clk = ~clk;

    if_fetch_buffer #(
        .FETCH_W (FW),
        .ISSUE_W (IW),
        .DEPTH   (D),
        .PC_W    (32),
        .INST_W  (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .int_pending_i (int_p),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_mask_i     (in_mask),
        .in_pc_i       (in_pc),
        .in_inst_i     (in_inst),
        .in_excep_i    (in_excep),
        .id_allowin_i  (allowin),
        .out_valid_o   (out_valid),
        .out_pc_o      (out_pc),
        .out_inst_o    (out_inst),
        .out_excep_o   (out_excep),
        .out_int_o     (out_int),
        .count_o       (count)
    );

    int unsigned  n_vec = 0;
    int unsigned  n_err = 0;
    fetch_entry_t q[$];
    logic [31:0]  pc_next = 32'h1c00_1000;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lines issue in order until the first exception (inclusive) or, beyond
    // line 0, any exception or pending interrupt.
    function automatic logic [IW-1:0] model_valid();
        logic [IW-1:0] v;
        v = '0;
        if (flush) return v;
        for (int k = 0; k < IW; k++) begin
            if (k >= q.size()) break;
            if (k > 0 && (int_p || q[k].excep)) break;
            v[k] = 1'b1;
            if (q[k].excep) break;
        end
        return v;
    endfunction

    function automatic logic model_ready();
        return !flush && ((D - q.size()) >= FW);
    endfunction

    task automatic check_model();
        logic [IW-1:0] ev;
        ev = model_valid();
        cmp("in_ready", 32'(in_ready), 32'(model_ready()));
        cmp("out_valid", 32'(out_valid), 32'(ev));
        cmp("out_int", 32'(out_int), 32'(int_p && ev[0]));
        cmp("count", 32'(count), 32'(q.size()));
        for (int k = 0; k < IW; k++) begin
            if (ev[k]) begin
                cmp("line_pc", out_pc[k*32 +: 32], q[k].pc);
                cmp("line_inst", out_inst[k*32 +: 32], q[k].inst);
                cmp("line_excep", 32'(out_excep[k]), 32'(q[k].excep));
            end
        end
    endtask

    // Drive one cycle's inputs at the negedge and check the settled outputs.
    task automatic drive(input logic v, input logic [FW-1:0] m, input logic [31:0] pcb,
                         input logic [FW-1:0] ex, input logic al, input logic fl,
                         input logic ip);
        @(negedge clk);
        in_valid = v;
        in_mask  = m;
        in_excep = ex;
        allowin  = al;
        flush    = fl;
        int_p    = ip;
        for (int k = 0; k < FW; k++) begin
            in_pc[k*32 +: 32]   = pcb + 32'(4 * k);
            in_inst[k*32 +: 32] = $urandom;
        end
        #1;
        check_model();
    endtask

    // Take the clock edge and apply the same transaction to the model.
    task automatic advance();
        logic [IW-1:0] ev;
        logic          rdy;
        fetch_entry_t  e;
        ev  = model_valid();
        rdy = model_ready();
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (allowin && ev[0]) begin
                for (int k = 0; k < $countones(ev); k++) void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                for (int k = 0; k < FW; k++) begin
                    if (in_mask[k]) begin
                        e.pc    = in_pc[k*32 +: 32];
                        e.inst  = in_inst[k*32 +: 32];
                        e.excep = in_excep[k];
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic idle(input logic al);
        drive(1'b0, '0, 32'h0, '0, al, 1'b0, 1'b0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        allowin  = 1'b0;
        int_p    = 1'b0;
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check_model();
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        int_p    = 1'b0;
        in_valid = 1'b0;
        in_mask  = '0;
        in_pc    = '0;
        in_inst  = '0;
        in_excep = '0;
        allowin  = 1'b0;
        #12;
        cmp("rst_out_valid", 32'(out_valid), 32'h0);
        cmp("rst_out_int", 32'(out_int), 32'h0);
        cmp("rst_count", 32'(count), 32'h0);
        cmp("rst_in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with four full groups, ID stalled.
        for (int g = 0; g < 4; g++) begin
            drive(1'b1, 2'b11, 32'h1c00_0000 + 32'(8 * g), 2'b00, 1'b0, 1'b0, 1'b0);
            advance();
        end
        idle(1'b0);
        cmp("full_count", 32'(count), 32'd8);
        cmp("full_in_ready", 32'(in_ready), 32'h0);
        cmp("full_out_valid", 32'(out_valid), 32'h3);
        cmp("full_pc0", out_pc[31:0], 32'h1c00_0000);
        cmp("full_pc1", out_pc[63:32], 32'h1c00_0004);
        advance();

        // Drain two per cycle.
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            cmp("drain_count", 32'(count), 32'(8 - 2 * i));
            cmp("drain_pc0", out_pc[31:0], 32'h1c00_0000 + 32'(8 * i));
            cmp("drain_pc1", out_pc[63:32], 32'h1c00_0004 + 32'(8 * i));
            advance();
        end
        idle(1'b1);
        cmp("empty_count", 32'(count), 32'd0);
        cmp("empty_out_valid", 32'(out_valid), 32'h0);
        advance();

        // Exception in slot 1 splits the group.
        drive(1'b1, 2'b11, 32'h1c00_0020, 2'b10, 1'b0, 1'b0, 1'b0);
        advance();
        idle(1'b1);
        cmp("exc_valid_a", 32'(out_valid), 32'h1);
        cmp("exc_pc_a", out_pc[31:0], 32'h1c00_0020);
        advance();
        idle(1'b1);
        cmp("exc_valid_b", 32'(out_valid), 32'h1);
        cmp("exc_pc_b", out_pc[31:0], 32'h1c00_0024);
        cmp("exc_flag_b", 32'(out_excep[0]), 32'h1);
        advance();

        // Interrupt pending with three entries.
        drive(1'b1, 2'b11, 32'h1c00_0040, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 2'b01, 32'h1c00_0048, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b0, '0, 32'h0, '0, 1'b1, 1'b0, 1'b1);
        cmp("int_count", 32'(count), 32'd3);
        cmp("int_valid", 32'(out_valid), 32'h1);
        cmp("int_tag", 32'(out_int), 32'h1);
        advance();
        idle(1'b0);
        cmp("int_after_count", 32'(count), 32'd2);
        advance();
        idle(1'b1);
        advance();

        // Flush while pushing and popping with five entries.
        drive(1'b1, 2'b11, 32'h1c00_0060, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 2'b11, 32'h1c00_0068, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 2'b01, 32'h1c00_0070, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 2'b11, 32'h1c00_0080, 2'b00, 1'b1, 1'b1, 1'b0);
        cmp("flush_pre_count", 32'(count), 32'd5);
        cmp("flush_valid", 32'(out_valid), 32'h0);
        cmp("flush_in_ready", 32'(in_ready), 32'h0);
        advance();
        idle(1'b0);
        cmp("flush_post_count", 32'(count), 32'd0);
        cmp("flush_post_ready", 32'(in_ready), 32'h1);
        advance();

        // Steady push+pop across pointer wrap.
        drive(1'b1, 2'b11, 32'h1c00_0100, 2'b00, 1'b0, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'b11, 32'h1c00_0108 + 32'(8 * i), 2'b00, 1'b1, 1'b0, 1'b0);
            cmp("wrap_count", 32'(count), 32'd2);
            cmp("wrap_pc0", out_pc[31:0], 32'h1c00_0100 + 32'(8 * i));
            advance();
        end
        idle(1'b1);
        advance();

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            logic [FW-1:0] m;
            logic [FW-1:0] ex;
            int unsigned   len;
            if (i == 1500) reset_mid();
            len = $urandom_range(0, FW);
            m   = FW'((1 << len) - 1);
            ex  = '0;
            for (int k = 0; k < FW; k++) ex[k] = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 9) < 7, m, pc_next, ex,
                  $urandom_range(0, 9) < (i < 1500 ? 4 : 7),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 9) == 0);
            pc_next = pc_next + 32'(4 * FW);
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
